// File: rtl/axis_frame_sink_pkg.sv
// Shared definitions for the AXI-Stream frame sink: FSM encoding and
// the constants of the pseudo-random backpressure generator.
package axis_frame_sink_pkg;

    // Frame tracking states.
    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } sink_state_t;

    // Backpressure LFSR: 16-bit Fibonacci, polynomial taps 16,14,13,11.
    localparam int          LFSR_WIDTH = 16;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    // Tap positions (1-based, as in the polynomial).
    localparam int LFSR_TAP_A = 16;
    localparam int LFSR_TAP_B = 14;
    localparam int LFSR_TAP_C = 13;
    localparam int LFSR_TAP_D = 11;

    // Mask of the register bits feeding the XOR (bit index = tap - 1).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Zero-extend a pixel of up to 32 bits into the 32-bit checksum domain.
    function automatic logic [31:0] pix_zext(input logic [31:0] pix);
        return pix;
    endfunction

endpackage : axis_frame_sink_pkg

// File: rtl/axis_frame_sink_lfsr16.sv
// 16-bit Fibonacci LFSR, steps every clock, loads the seed on reset.
module lfsr16
    import axis_frame_sink_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    output logic [15:0] q
);

    logic [15:0] q_reg;
    logic [15:0] q_next;
    logic        feedback;

    // XOR of the tapped bits shifts in at the bottom.
    assign feedback = ^(q_reg & LFSR_TAPS);
    assign q_next[0] = feedback;

    genvar gi;
    generate
        for (gi = 1; gi < LFSR_WIDTH; gi++) begin : g_shift
            assign q_next[gi] = q_reg[gi-1];
        end
    endgenerate

    // Shift register with asynchronous seed load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_reg <= LFSR_SEED;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule : lfsr16

// File: rtl/axis_frame_sink.sv
// AXI-Stream video frame sink: tracks SOF/EOL framing, counts complete
// frames, checksums each frame and flags framing errors. Optional
// pseudo-random backpressure from an LFSR.
module axis_frame_sink
    import axis_frame_sink_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 2560,
    parameter int IMG_HEIGHT = 1440
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  throttle_en,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic [31:0]           checksum,
    output logic                  err_short,
    output logic                  err_long,
    output logic                  err_sof
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    sink_state_t   state_reg, state_next;
    logic [XW-1:0] x_reg, x_next;
    logic [YW-1:0] y_reg, y_next;
    logic [31:0]   acc_reg, acc_next;
    logic [31:0]   checksum_reg, checksum_next;
    logic [15:0]   frame_cnt_reg, frame_cnt_next;
    logic          frame_done_reg, frame_done_next;
    logic          err_short_reg, err_short_next;
    logic          err_long_reg, err_long_next;
    logic          err_sof_reg, err_sof_next;
    logic          tready_reg, tready_next;

    logic [15:0]   lfsr_q;
    logic          xfer;

    // Per-transfer working values.
    logic          take;
    logic [XW-1:0] line_x;
    logic [YW-1:0] line_y;
    logic [31:0]   acc_sum;
    logic          last_col;
    logic          line_end;

    lfsr16 u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .q      (lfsr_q)
    );

    assign xfer = s_axis_tvalid & tready_reg;

    // tready is a pure register of throttle/LFSR so it never depends on tvalid.
    always_comb begin
        tready_next = throttle_en ? lfsr_q[0] : 1'b1;
    end

    // Framing FSM, counters, accumulator and sticky error flags.
    always_comb begin
        state_next      = state_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        acc_next        = acc_reg;
        checksum_next   = checksum_reg;
        frame_cnt_next  = frame_cnt_reg;
        frame_done_next = 1'b0;
        err_short_next  = err_short_reg;
        err_long_next   = err_long_reg;
        err_sof_next    = err_sof_reg;

        take     = 1'b0;
        line_x   = x_reg;
        line_y   = y_reg;
        acc_sum  = acc_reg + pix_zext(32'(s_axis_tdata));
        last_col = 1'b0;
        line_end = 1'b0;

        if (xfer) begin
            if (s_axis_tuser) begin
                // SOF always (re)starts a frame at pixel 0,0 with a fresh sum;
                // mid-frame it abandons the current frame.
                take    = 1'b1;
                line_x  = '0;
                line_y  = '0;
                acc_sum = pix_zext(32'(s_axis_tdata));
                if (state_reg == IN_FRAME) begin
                    err_sof_next = 1'b1;
                end
            end else if (state_reg == IN_FRAME) begin
                take = 1'b1;
            end
        end

        if (take) begin
            last_col   = (line_x == X_LAST);
            line_end   = s_axis_tlast | last_col;
            acc_next   = acc_sum;
            state_next = IN_FRAME;

            if (s_axis_tlast && !last_col) begin
                err_short_next = 1'b1;
            end
            if (!s_axis_tlast && last_col) begin
                err_long_next = 1'b1;
            end

            if (line_end) begin
                x_next = '0;
                if (line_y == Y_LAST) begin
                    state_next      = WAIT_SOF;
                    y_next          = '0;
                    acc_next        = '0;
                    checksum_next   = acc_sum;
                    frame_cnt_next  = frame_cnt_reg + 16'd1;
                    frame_done_next = 1'b1;
                end else begin
                    y_next = line_y + YW'(1);
                end
            end else begin
                x_next = line_x + XW'(1);
                y_next = line_y;
            end
        end
    end

    // State registers with asynchronous clear; reset abandons any partial frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= WAIT_SOF;
            x_reg          <= '0;
            y_reg          <= '0;
            acc_reg        <= '0;
            checksum_reg   <= '0;
            frame_cnt_reg  <= '0;
            frame_done_reg <= 1'b0;
            err_short_reg  <= 1'b0;
            err_long_reg   <= 1'b0;
            err_sof_reg    <= 1'b0;
            tready_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            acc_reg        <= acc_next;
            checksum_reg   <= checksum_next;
            frame_cnt_reg  <= frame_cnt_next;
            frame_done_reg <= frame_done_next;
            err_short_reg  <= err_short_next;
            err_long_reg   <= err_long_next;
            err_sof_reg    <= err_sof_next;
            tready_reg     <= tready_next;
        end
    end

    assign s_axis_tready = tready_reg;
    assign frame_done    = frame_done_reg;
    assign frame_cnt     = frame_cnt_reg;
    assign checksum      = checksum_reg;
    assign err_short     = err_short_reg;
    assign err_long      = err_long_reg;
    assign err_sof       = err_sof_reg;

endmodule : axis_frame_sink
